// File: rtl/mips_avalon_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_avalon_pkg
// Purpose : Shared definitions for the MIPS Avalon-MM master: access-size
//           encodings, FSM state type, byte-enable and alignment helpers.
// Revision: 1.0 - initial release
// ============================================================================
package mips_avalon_pkg;

  // Core access-size encoding (cpu_size); 2'd3 is illegal.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte lanes touched by an access of the given size at byte offset ofs.
  function automatic logic [3:0] gen_byteenable(input logic [1:0] size,
                                                input logic [1:0] ofs);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << ofs;
      SZ_HALF: be = ofs[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // True for accesses that cannot be issued as a single aligned bus cycle,
  // including the illegal size code.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] ofs);
    return ((size == SZ_HALF) && ofs[0])
        || ((size == SZ_WORD) && (ofs != 2'b00))
        || (size == 2'd3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_avalon_lane.sv
`default_nettype none
// ============================================================================
// Module  : mips_avalon_lane
// Purpose : Combinational lane formatter for the Avalon master.
//           Store side: byte enables and lane-replicated write data.
//           Load side : lane select plus zero/sign extension of read data.
// Ports   : st_size, st_ofs, st_wdata -> st_be, st_wdata_rep
//           ld_size, ld_ofs, ld_signed, ld_rdata -> ld_data
// Revision: 1.0 - initial release
// ============================================================================
module mips_avalon_lane
  import mips_avalon_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_ofs,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata_rep,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_ofs,
  input  logic        ld_signed,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Replicating the right-aligned store data across all lanes lets the
  // byte enables alone pick the destination bytes.
  always_comb begin
    st_be = gen_byteenable(st_size, st_ofs);
    case (st_size)
      SZ_BYTE: st_wdata_rep = {4{st_wdata[7:0]}};
      SZ_HALF: st_wdata_rep = {2{st_wdata[15:0]}};
      default: st_wdata_rep = st_wdata;
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata[{ld_ofs, 3'b000} +: 8];
    ld_half = ld_ofs[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_signed & ld_half[15]}}, ld_half};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_avalon_master.sv
`default_nettype none
// ============================================================================
// Module  : mips_avalon_master
// Purpose : Bus interface unit between the MIPS core load/store/fetch port
//           and an Avalon-MM slave. One outstanding transaction at a time.
// Ports   : clk, reset_n (async, active low)
//           core side : cpu_req_valid/ready, cpu_we, cpu_addr, cpu_size,
//                       cpu_signed, cpu_wdata, cpu_rsp_valid, cpu_rdata, cpu_err
//           Avalon    : address, read, write, writedata, byteenable,
//                       waitrequest, readdata
// Revision: 1.0 - initial release
// ============================================================================
module mips_avalon_master
  import mips_avalon_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_rsp_valid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam logic             TMO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t           state;
  logic [1:0]       size_q;
  logic [1:0]       ofs_q;
  logic             signed_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] tmo_cnt_inc;

  logic [3:0]       st_be;
  logic [31:0]      st_wdata_rep;
  logic [31:0]      ld_data;

  // Store formatting works on the live request; load formatting works on the
  // fields captured at acceptance, since the core may change its inputs.
  mips_avalon_lane u_lane (
    .st_size      (cpu_size),
    .st_ofs       (cpu_addr[1:0]),
    .st_wdata     (cpu_wdata),
    .st_be        (st_be),
    .st_wdata_rep (st_wdata_rep),
    .ld_size      (size_q),
    .ld_ofs       (ofs_q),
    .ld_signed    (signed_q),
    .ld_rdata     (readdata),
    .ld_data      (ld_data)
  );

  assign cpu_req_ready = (state == ST_IDLE);
  assign tmo_cnt_inc   = tmo_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      read          <= 1'b0;
      write         <= 1'b0;
      address       <= '0;
      writedata     <= '0;
      byteenable    <= '0;
      size_q        <= '0;
      ofs_q         <= '0;
      signed_q      <= 1'b0;
      tmo_cnt       <= '0;
      cpu_rsp_valid <= 1'b0;
      cpu_err       <= 1'b0;
      cpu_rdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req_valid) begin
            if (is_misaligned(cpu_size, cpu_addr[1:0])) begin
              // Rejected without touching the bus.
              state         <= ST_RESP;
              cpu_rsp_valid <= 1'b1;
              cpu_err       <= 1'b1;
              cpu_rdata     <= '0;
            end else begin
              state      <= ST_BUS;
              address    <= {cpu_addr[31:2], 2'b00};
              byteenable <= st_be;
              writedata  <= st_wdata_rep;
              size_q     <= cpu_size;
              ofs_q      <= cpu_addr[1:0];
              signed_q   <= cpu_signed;
              read       <= ~cpu_we;
              write      <= cpu_we;
            end
          end
        end

        ST_BUS: begin
          // A completing transfer takes priority over an expiring timeout.
          if (!waitrequest) begin
            state         <= ST_RESP;
            read          <= 1'b0;
            write         <= 1'b0;
            cpu_rsp_valid <= 1'b1;
            cpu_err       <= 1'b0;
            cpu_rdata     <= write ? 32'd0 : ld_data;
          end else if (TMO_EN && (tmo_cnt_inc == TMO_LIMIT)) begin
            state         <= ST_RESP;
            read          <= 1'b0;
            write         <= 1'b0;
            cpu_rsp_valid <= 1'b1;
            cpu_err       <= 1'b1;
            cpu_rdata     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt_inc;
          end
        end

        ST_RESP: begin
          state         <= ST_IDLE;
          cpu_rsp_valid <= 1'b0;
          cpu_err       <= 1'b0;
          tmo_cnt       <= '0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_avalon_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_avalon_master
// Purpose : Directed self-checking bench for mips_avalon_master with a small
//           Avalon slave model (programmable wait states, byte-enabled
//           memory of 16 words indexed by address[5:2]).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips_avalon_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [1:0]  cpu_size;
  logic        cpu_signed;
  logic [31:0] cpu_wdata;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  int checks = 0;
  int errors = 0;

  // Slave model state
  logic [31:0] mem [0:15];
  int          rd_delay;
  logic        force_wait;
  int          wcnt;
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_val;

  // Per-transaction observations
  int          r_lat, r_busn, r_hold, r_both;
  logic [31:0] r_rdata, obs_addr, obs_wd;
  logic [3:0]  obs_be;
  logic        r_err, obs_rd, obs_wr, r_ready_resp, r_ready_after, r_rsp_after;
  int          rsp_cnt;

  always #5 clk = ~clk;

  mips_avalon_master #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_size      (cpu_size),
    .cpu_signed    (cpu_signed),
    .cpu_wdata     (cpu_wdata),
    .cpu_rsp_valid (cpu_rsp_valid),
    .cpu_rdata     (cpu_rdata),
    .cpu_err       (cpu_err),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .waitrequest   (waitrequest),
    .readdata      (readdata)
  );

  assign waitrequest = force_wait || (wcnt < rd_delay);
  assign readdata    = mem[address[5:2]];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           wcnt <= 0;
    else if ((read || write) && !waitrequest) wcnt <= 0;
    else if (read || write)                 wcnt <= wcnt + 1;
    else                                    wcnt <= 0;
  end

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (write && !waitrequest)
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mem[address[5:2]][8*i +: 8] <= writedata[8*i +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request and follow it to its response. r_lat counts cycles from
  // the first falling edge after acceptance (0 = response in the very next cycle).
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] wdata);
    @(negedge clk);
    check("ready_before", {31'd0, cpu_req_ready}, 32'd1);
    cpu_req_valid = 1'b1; cpu_we = we; cpu_addr = addr;
    cpu_size = size; cpu_signed = sgn; cpu_wdata = wdata;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    cpu_addr = 32'hDEAD_BEEF; cpu_wdata = 32'h5555_5555; cpu_size = 2'd3;
    r_lat = -1; r_busn = 0; r_hold = 0; r_both = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (read || write) begin
        if (r_busn == 0) begin
          obs_addr = address; obs_be = byteenable; obs_wd = writedata;
          obs_rd = read; obs_wr = write;
        end else if ({address, byteenable, writedata, read, write} !=
                     {obs_addr, obs_be, obs_wd, obs_rd, obs_wr}) begin
          r_hold++;
        end
        if (read && write) r_both++;
        r_busn++;
      end
      if (cpu_rsp_valid) begin
        r_lat = n; r_rdata = cpu_rdata; r_err = cpu_err; r_ready_resp = cpu_req_ready;
        break;
      end
    end
    @(negedge clk);
    r_rsp_after = cpu_rsp_valid; r_ready_after = cpu_req_ready;
    check("rsp_seen", {31'd0, (r_lat >= 0)}, 32'd1);
    check("bus_hold", 32'(r_hold), 32'd0);
    check("rd_wr_excl", 32'(r_both), 32'd0);
    check("rsp_one_cycle", {31'd0, r_rsp_after}, 32'd0);
    check("ready_in_resp", {31'd0, r_ready_resp}, 32'd0);
    check("ready_after", {31'd0, r_ready_after}, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; cpu_req_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    cpu_size = '0; cpu_signed = 1'b0; cpu_wdata = '0;
    rd_delay = 2; force_wait = 1'b0; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
    for (int i = 0; i < 16; i++) preload(4'(i), 32'd0);

    // Reset state
    #1;
    check("rst_read", {31'd0, read}, 32'd0);
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_rsp", {31'd0, cpu_rsp_valid}, 32'd0);
    check("rst_err", {31'd0, cpu_err}, 32'd0);
    check("rst_addr", address, 32'd0);
    check("rst_be", {28'd0, byteenable}, 32'd0);
    check("rst_wd", writedata, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, cpu_req_ready}, 32'd1);

    // Word fetch, two wait states
    preload(4'd0, 32'h8C22_0004);
    do_req(1'b0, 32'hBFC0_0000, 2'd2, 1'b0, 32'd0);
    check("wl_read", {31'd0, obs_rd}, 32'd1);
    check("wl_write", {31'd0, obs_wr}, 32'd0);
    check("wl_addr", obs_addr, 32'hBFC0_0000);
    check("wl_be", {28'd0, obs_be}, 32'hF);
    check("wl_lat", 32'(r_lat), 32'd3);
    check("wl_rdata", r_rdata, 32'h8C22_0004);
    check("wl_err", {31'd0, r_err}, 32'd0);

    // Byte store, then read back the word
    do_req(1'b1, 32'h0000_0006, 2'd0, 1'b0, 32'h0000_00AB);
    check("bs_write", {31'd0, obs_wr}, 32'd1);
    check("bs_read", {31'd0, obs_rd}, 32'd0);
    check("bs_addr", obs_addr, 32'h0000_0004);
    check("bs_be", {28'd0, obs_be}, 32'h4);
    check("bs_wd", obs_wd, 32'hABAB_ABAB);
    check("bs_rdata", r_rdata, 32'd0);
    check("bs_err", {31'd0, r_err}, 32'd0);
    do_req(1'b0, 32'h0000_0004, 2'd2, 1'b0, 32'd0);
    check("bs_readback", r_rdata, 32'h00AB_0000);

    // Half store replicates and enables the upper lanes
    do_req(1'b1, 32'h0000_000A, 2'd1, 1'b0, 32'h1234_BEEF);
    check("hs_be", {28'd0, obs_be}, 32'hC);
    check("hs_wd", obs_wd, 32'hBEEF_BEEF);
    do_req(1'b0, 32'h0000_0008, 2'd2, 1'b0, 32'd0);
    check("hs_readback", r_rdata, 32'hBEEF_0000);

    // Sub-word loads and extension
    preload(4'd0, 32'h8001_1234);
    do_req(1'b0, 32'h0000_0002, 2'd1, 1'b1, 32'd0);
    check("hl_signed", r_rdata, 32'hFFFF_8001);
    check("hl_be", {28'd0, obs_be}, 32'hC);
    do_req(1'b0, 32'h0000_0002, 2'd1, 1'b0, 32'd0);
    check("hl_unsigned", r_rdata, 32'h0000_8001);
    do_req(1'b0, 32'h0000_0003, 2'd0, 1'b1, 32'd0);
    check("bl3_signed", r_rdata, 32'hFFFF_FF80);
    check("bl3_be", {28'd0, obs_be}, 32'h8);
    do_req(1'b0, 32'h0000_0000, 2'd0, 1'b0, 32'd0);
    check("bl0_unsigned", r_rdata, 32'h0000_0034);
    do_req(1'b0, 32'h0000_0000, 2'd1, 1'b1, 32'd0);
    check("hl0_signed", r_rdata, 32'h0000_1234);

    // Zero wait states: minimum latency
    rd_delay = 0;
    do_req(1'b0, 32'h0000_0000, 2'd2, 1'b0, 32'd0);
    check("z_lat", 32'(r_lat), 32'd1);
    check("z_rdata", r_rdata, 32'h8001_1234);

    // Misaligned and illegal requests never reach the bus
    do_req(1'b0, 32'h0000_0001, 2'd2, 1'b0, 32'd0);
    check("mis_w_bus", 32'(r_busn), 32'd0);
    check("mis_w_lat", 32'(r_lat), 32'd0);
    check("mis_w_err", {31'd0, r_err}, 32'd1);
    check("mis_w_rdata", r_rdata, 32'd0);
    do_req(1'b0, 32'h0000_0000, 2'd2, 1'b0, 32'd0);
    check("mis_recover", r_rdata, 32'h8001_1234);
    do_req(1'b1, 32'h0000_0000, 2'd3, 1'b0, 32'h1111_1111);
    check("ill_bus", 32'(r_busn), 32'd0);
    check("ill_lat", 32'(r_lat), 32'd0);
    check("ill_err", {31'd0, r_err}, 32'd1);
    check("ill_rdata", r_rdata, 32'd0);
    do_req(1'b1, 32'h0000_0003, 2'd1, 1'b0, 32'h2222_2222);
    check("mis_h_bus", 32'(r_busn), 32'd0);
    check("mis_h_err", {31'd0, r_err}, 32'd1);

    // Timeout with waitrequest stuck high
    do_req(1'b0, 32'h0000_0000, 2'd2, 1'b0, 32'd0);
    force_wait = 1'b1;
    do_req(1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'd0);
    check("to_bus_cycles", 32'(r_busn), 32'd16);
    check("to_lat", 32'(r_lat), 32'd16);
    check("to_err", {31'd0, r_err}, 32'd1);
    check("to_rdata", r_rdata, 32'd0);
    force_wait = 1'b0;

    // Reset during a stalled write
    rd_delay = 2; force_wait = 1'b1;
    preload(4'd2, 32'h1234_5678);
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0008;
    cpu_size = 2'd2; cpu_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    @(negedge clk);
    check("mr_write_up", {31'd0, write}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mr_write_drop", {31'd0, write}, 32'd0);
    check("mr_read_low", {31'd0, read}, 32'd0);
    rsp_cnt = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (cpu_rsp_valid) rsp_cnt++;
    end
    force_wait = 1'b0;
    reset_n = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (cpu_rsp_valid) rsp_cnt++;
    end
    check("mr_no_rsp", 32'(rsp_cnt), 32'd0);
    check("mr_ready", {31'd0, cpu_req_ready}, 32'd1);
    do_req(1'b0, 32'h0000_0008, 2'd2, 1'b0, 32'd0);
    check("mr_load", r_rdata, 32'h1234_5678);
    check("mr_load_err", {31'd0, r_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_avalon_master.md
Name: mips_avalon_master

Overview:
- Avalon memory-mapped master (bus interface unit) between the MIPS core's load/store/fetch port and the memory-mapped slaves on the test bus.
- Converts one core request (byte, half or word; signed or unsigned) into a word-aligned Avalon read or write with byteenable and lane-replicated writedata.
- Holds the transfer stable through waitrequest, then returns extended read data or an error to the core.
- One outstanding transaction at a time.

Parameters:
- TIMEOUT_CYCLES, 0: cycles in BUS with waitrequest high before abort; 0 disables the timeout.
- CNT_W, 16: width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- cpu_req_valid  input  1  core request present.
- cpu_req_ready  output  1  master can accept a request; high only in IDLE.
- cpu_we  input  1  1 = store, 0 = load.
- cpu_addr  input  32  byte address.
- cpu_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- cpu_signed  input  1  sign-extend load data.
- cpu_wdata  input  32  store data, right-aligned.
- cpu_rsp_valid  output  1  one-cycle response pulse.
- cpu_rdata  output  32  extended load data; 0 for stores and errors.
- cpu_err  output  1  qualifies cpu_rsp_valid: misalign, illegal size or timeout.
- address  output  32  Avalon word-aligned byte address.
- read  output  1  Avalon read.
- write  output  1  Avalon write.
- writedata  output  32  Avalon write data.
- byteenable  output  4  Avalon byte enables.
- waitrequest  input  1  Avalon stall. May be combinational on read/write.
- readdata  input  32  Avalon read data, valid on the cycle waitrequest is low.

Behaviour:
- Reset (asynchronous, effective immediately):
  - state = IDLE.
  - read, write, cpu_rsp_valid, cpu_err = 0.
  - address, writedata, byteenable, cpu_rdata = 0; timeout counter = 0.
  - cpu_req_ready = 1 once reset_n is high.
- States: IDLE, BUS, RESP.
- IDLE, on cpu_req_valid & cpu_req_ready at a clock edge:
  - Misaligned if (size = 1 and addr[0] = 1), (size = 2 and addr[1:0] != 0), or size = 3.
  - If misaligned, go to RESP with err = 1 and issue no bus cycle.
  - Otherwise register all request fields and go to BUS.
  - address = {addr[31:2], 2'b00}.
  - byteenable: byte = 4'b0001 << addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
  - writedata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- BUS:
  - read = ~we and write = we; read and write are never high together.
  - address, byteenable, writedata are held constant for the whole state.
  - On an edge with waitrequest = 0: capture the formatted readdata for loads, clear read/write, go to RESP with err = 0.
  - Byte load selects readdata[8*addr[1:0] +: 8]. Half load selects readdata[16*addr[1] +: 16].
  - Selected data is zero- or sign-extended according to cpu_signed.
  - The timeout counter increments on each BUS edge with waitrequest = 1.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES: clear read/write, go to RESP with err = 1, cpu_rdata = 0.
  - waitrequest low on the same edge as the timeout wins: the transfer completes normally.
- RESP:
  - cpu_rsp_valid = 1 for exactly one cycle; cpu_rdata and cpu_err are valid in that cycle.
  - Next state IDLE; the timeout counter clears.
  - cpu_req_ready = 0, so back-to-back requests are accepted no earlier than the cycle after RESP.
- Latency (accept edge = edge 0):
  - read/write asserted from edge 0 to edge N, where N = first edge with waitrequest low (N ≥ 1).
  - cpu_rsp_valid high in the cycle after edge N.
  - Minimum: response 2 cycles after acceptance. Misaligned: response 1 cycle after acceptance.
- cpu_rsp_valid, cpu_err and cpu_rdata are registered outputs. cpu_rdata holds its value until the next response.
- A reset mid-BUS drops read/write asynchronously. The aborted transfer is not reported to the core.

Decomposition:
- mips_avalon_pkg holds:
  - size encoding constants SZ_BYTE, SZ_HALF, SZ_WORD.
  - the state enum (IDLE, BUS, RESP).
  - pure functions for byteenable generation and alignment check.
- One sub-module, mips_avalon_lane: combinational formatter.
  - Store direction: size and addr[1:0] → byteenable and replicated writedata.
  - Load direction: readdata, size, addr[1:0], signed → extended data.
  - Instantiated once in the master.

Test Plan:
- Word load at 0xBFC00000, slave READ_DELAY = 2, memory word 0x8C220004.
  → read held with address 0xBFC00000 and byteenable 1111; no address change while waitrequest is high.
  → cpu_rsp_valid one cycle after waitrequest falls; cpu_rdata = 0x8C220004, err = 0.
- Byte store 0x000000AB to 0x00000006.
  → write = 1, address 0x00000004, byteenable 0100, writedata 0xABABABAB.
  → subsequent word read returns 0x00AB0000 when memory was zero.
- Half load at 0x00000002 with readdata 0x8001_1234.
  → signed: cpu_rdata = 0xFFFF8001. Unsigned: 0x00008001.
  → byte load at 0x3, signed: 0xFFFFFF80.
- Word load at 0x00000001, and any request with size = 3.
  → read/write never asserted; cpu_rsp_valid the cycle after acceptance with cpu_err = 1, cpu_rdata = 0.
- TIMEOUT_CYCLES = 16, waitrequest forced high.
  → read high for exactly 16 edges, then low; rsp with err = 1; master back in IDLE with req_ready = 1.
- reset_n pulled low during BUS of a write.
  → write drops in the same cycle without waiting for a clock edge; no rsp pulse.
  → after release, req_ready = 1 and a new word load completes normally.
